// File: rtl/seq_divider_hs.sv
// Multi-cycle restoring unsigned divider with valid/ready handshakes; STEPS quotient bits per clock.
// Optional DIV_EARLY_TERM_EN adds single-cycle paths for trivial operands (results unchanged).
module seq_divider_hs #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned NCYC = WIDTH / STEPS;
  localparam int unsigned CW   = $clog2(NCYC + 1);

  generate
    if (!((STEPS == 1) || (STEPS == 2) || (STEPS == 4)) || ((WIDTH % STEPS) != 0)) begin : g_bad_cfg
      $error("seq_divider_hs: STEPS must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem, prem_nx;
  logic [WIDTH-1:0] acc, acc_nx, dsr;
  logic [WIDTH-1:0] q_r, r_r;
  logic             dbz_r;
  logic             accept;
  logic             short_hit, short_dbz;
  logic [WIDTH-1:0] short_q, short_r;

  assign accept      = in_valid && (state == IDLE);
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign quotient    = q_r;
  assign remainder   = r_r;
  assign div_by_zero = dbz_r;

  // Operands that resolve without iterating go straight to DONE on the accept edge.
  always_comb begin
    short_hit = 1'b0;
    short_dbz = 1'b0;
    short_q   = '0;
    short_r   = '0;
    if (divisor == '0) begin
      short_hit = 1'b1;
      short_dbz = 1'b1;
      short_q   = '1;
      short_r   = dividend;
    end
`ifdef DIV_EARLY_TERM_EN
    else if (dividend < divisor) begin
      short_hit = 1'b1;
      short_r   = dividend;
    end else if (divisor == WIDTH'(1)) begin
      short_hit = 1'b1;
      short_q   = dividend;
    end else if (dividend == divisor) begin
      short_hit = 1'b1;
      short_q   = WIDTH'(1);
    end
`endif
  end

  // acc shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    prem_nx = prem;
    acc_nx  = acc;
    for (int unsigned i = 0; i < STEPS; i++) begin
      prem_nx = {prem_nx[WIDTH-1:0], acc_nx[WIDTH-1]};
      acc_nx  = acc_nx << 1;
      if (prem_nx >= {1'b0, dsr}) begin
        prem_nx   = prem_nx - {1'b0, dsr};
        acc_nx[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = short_hit ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prem  <= '0;
      acc   <= '0;
      dsr   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            prem <= '0;
            acc  <= dividend;
            dsr  <= divisor;
            cnt  <= CW'(NCYC);
            if (short_hit) begin
              q_r   <= short_q;
              r_r   <= short_r;
              dbz_r <= short_dbz;
            end
          end
        end
        CALC: begin
          prem <= prem_nx;
          acc  <= acc_nx;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            q_r   <= acc_nx;
            r_r   <= prem_nx[WIDTH-1:0];
            dbz_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
